// File: rtl/serial_adder_8b_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_adder_8b_pkg;

   // Default operand/result width.
   localparam int unsigned NBITS_DEFAULT = 8;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Width of a counter indexing n bit positions, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_8b_full_adder_1b.sv
// One-bit full adder used for each serial step of the adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller sequences the operand bits.
module full_adder_1b (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic half_sum;

   // Propagate term is shared between the sum and the carry.
   assign half_sum = a ^ b;
   assign sum      = half_sum ^ cin;
   assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/serial_adder_8b.sv
// Bit-serial adder: accepts an operand pair, adds one bit per cycle LSB first.
// Latency: out_val rises NBITS edges after the acceptance edge; one idle cycle after consumption.
// Backpressure: result held in DONE while out_rdy=0; in_rdy is low from acceptance to consumption.
// Optional: define SERIAL_ADDER_OVFL_EN to add the signed-overflow output ovfl.
module serial_adder_8b
   import serial_adder_8b_pkg::*;
#(
   parameter int NBITS = NBITS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [NBITS-1:0] in0,
   input  logic [NBITS-1:0] in1,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [NBITS-1:0] out
`ifdef SERIAL_ADDER_OVFL_EN
   ,
   output logic             ovfl
`endif
);

   localparam int              CNT_W    = cnt_width(NBITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

   state_e           state_q;
   logic [NBITS-1:0] a_q;
   logic [NBITS-1:0] b_q;
   logic [NBITS-1:0] res_q;
   logic [NBITS-1:0] res_d;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             in_rdy_q;
   logic             out_val_q;
`ifdef SERIAL_ADDER_OVFL_EN
   logic             ovfl_q;
`endif

   logic sum_bit;
   logic carry_out;

   // The single adder cell always sees the current LSBs of the operand shifters.
   full_adder_1b u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (sum_bit),
      .cout (carry_out)
   );

   // Result shifter: new sum bit enters at the MSB so the LSB lands at bit 0 after NBITS steps.
   always_comb begin
      res_d            = res_q >> 1;
      res_d[NBITS-1]   = sum_bit;
   end

   // Controller, counter, operand shifters and result register with registered handshake outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
         in_rdy_q  <= 1'b1;
         out_val_q <= 1'b0;
`ifdef SERIAL_ADDER_OVFL_EN
         ovfl_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_val) begin
                  a_q      <= in0;
                  b_q      <= in1;
                  carry_q  <= 1'b0;
                  cnt_q    <= '0;
                  in_rdy_q <= 1'b0;
                  state_q  <= ST_CALC;
               end
            end
            ST_CALC: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= carry_out;
               res_q   <= res_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  // Carry out of the MSB is dropped; only the wrapped sum is kept.
                  out_val_q <= 1'b1;
                  state_q   <= ST_DONE;
`ifdef SERIAL_ADDER_OVFL_EN
                  ovfl_q    <= carry_q ^ carry_out;
`endif
               end
            end
            ST_DONE: begin
               // Return through IDLE so no operands are taken on the consume edge.
               if (out_rdy) begin
                  out_val_q <= 1'b0;
                  in_rdy_q  <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end
            default: begin
               out_val_q <= 1'b0;
               in_rdy_q  <= 1'b1;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_rdy  = in_rdy_q;
   assign out_val = out_val_q;
   assign out     = res_q;
`ifdef SERIAL_ADDER_OVFL_EN
   assign ovfl    = ovfl_q;
`endif

endmodule

// File: tb/tb_serial_adder_8b.sv
// Self-checking bench for serial_adder_8b: directed corner sums, backpressure, reset abort, random pairs.
// Latency: expects out_val exactly 8 edges after acceptance.
// Backpressure: drives random out_rdy stalls and in_val noise while busy.
module tb_serial_adder_8b;

   localparam int NB = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_val = 1'b0;
   logic       in_rdy;
   logic [7:0] in0 = 8'h00;
   logic [7:0] in1 = 8'h00;
   logic       out_val;
   logic       out_rdy = 1'b0;
   logic [7:0] out_w;
`ifdef SERIAL_ADDER_OVFL_EN
   logic       ovfl;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder_8b #(.NBITS(NB)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .in_val  (in_val),
      .in_rdy  (in_rdy),
      .in0     (in0),
      .in1     (in1),
      .out_val (out_val),
      .out_rdy (out_rdy),
      .out     (out_w)
`ifdef SERIAL_ADDER_OVFL_EN
      ,
      .ovfl    (ovfl)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: an operation is outstanding from acceptance until consumption;
   // its result is visible once NB clock edges have elapsed since acceptance.
   bit         m_busy = 1'b0;
   int         m_age  = 0;
   logic [7:0] m_sum  = 8'h00;
   bit         m_ov   = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy = 1'b0;
         m_age  = 0;
      end else if (!m_busy) begin
         if (in_val === 1'b1) begin
            int s;
            m_busy = 1'b1;
            m_age  = 0;
            m_sum  = 8'((int'(in0) + int'(in1)) % 256);
            s      = int'($signed(in0)) + int'($signed(in1));
            m_ov   = (s > 127) || (s < -128);
         end
      end else if (m_age >= NB) begin
         if (out_rdy === 1'b1) m_busy = 1'b0;
      end else begin
         m_age++;
      end
   end

   // Every cycle, away from the active edge, compare the DUT against the model.
   always @(negedge clk) begin
      chk("in_rdy", in_rdy, {31'd0, !m_busy});
      chk("out_val", out_val, {31'd0, (m_busy && m_age >= NB)});
      if (m_busy && m_age >= NB) begin
         chk("out", out_w, {24'd0, m_sum});
`ifdef SERIAL_ADDER_OVFL_EN
         chk("ovfl", ovfl, {31'd0, m_ov});
`endif
      end
      if (!reset_n) chk("out_in_reset", out_w, 32'd0);
   end

   // One full operation with literal expectations and a DONE stall of 'stall' cycles.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input bit exp_ov, input int stall);
      int n;
      int t0;
      n = 0;
      while (in_rdy !== 1'b1 && n < 64) begin
         @(posedge clk); #1; n++;
      end
      chk("wait_in_rdy", in_rdy, 32'd1);
      in0 = a; in1 = b; in_val = 1'b1;
      @(posedge clk); #1;
      t0 = cyc;
      in_val = 1'b0;
      in0 = 8'($urandom); in1 = 8'($urandom);
      n = 0;
      while (out_val !== 1'b1 && n < 40) begin
         in_val  = 1'($urandom_range(0, 1));
         out_rdy = 1'($urandom_range(0, 1));
         in0 = 8'($urandom); in1 = 8'($urandom);
         @(posedge clk); #1; n++;
      end
      out_rdy = 1'b0;
      chk("latency", cyc - t0, 32'd8);
      chk("sum", out_w, {24'd0, exp});
`ifdef SERIAL_ADDER_OVFL_EN
      chk("ovfl_lit", ovfl, {31'd0, exp_ov});
`endif
      repeat (stall) begin
         in_val = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk("hold_val", out_val, 32'd1);
         chk("hold_out", out_w, {24'd0, exp});
         chk("hold_in_rdy", in_rdy, 32'd0);
      end
      // Offer new operands on the consume edge; they must not be taken.
      out_rdy = 1'b1; in_val = 1'b1;
      @(posedge clk); #1;
      out_rdy = 1'b0; in_val = 1'b0;
      chk("no_bypass", in_rdy, 32'd1);
      chk("released", out_val, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      void'($urandom(32'h5EED_0ADD));
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_rdy", in_rdy, 32'd1);
      chk("rst_out_val", out_val, 32'd0);
      chk("rst_out", out_w, 32'd0);
`ifdef SERIAL_ADDER_OVFL_EN
      chk("rst_ovfl", ovfl, 32'd0);
`endif
      #2 reset_n = 1'b1;
      @(posedge clk); #1;

      // Directed corner sums.
      do_op(8'd0,   8'd0,   8'h00, 1'b0, 0);
      do_op(8'd42,  8'd13,  8'h37, 1'b0, 1);
      do_op(8'd127, 8'd1,   8'h80, 1'b1, 0);
      do_op(8'hFF,  8'h01,  8'h00, 1'b0, 2);
      do_op(8'hD6,  8'hF3,  8'hC9, 1'b0, 0);
      do_op(8'h80,  8'hFF,  8'h7F, 1'b1, 0);
      // Backpressure: five stalled cycles in DONE.
      do_op(8'h5C,  8'h21,  8'h7D, 1'b0, 5);

      // Reset during CALC at bit 3 aborts the operation.
      in0 = 8'h5A; in1 = 8'h33; in_val = 1'b1;
      @(posedge clk); #1;
      in_val = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_in_rdy", in_rdy, 32'd1);
      chk("abort_out_val", out_val, 32'd0);
      chk("abort_out", out_w, 32'd0);
`ifdef SERIAL_ADDER_OVFL_EN
      chk("abort_ovfl", ovfl, 32'd0);
`endif
      @(posedge clk); #3;
      reset_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         chk("no_stale_val", out_val, 32'd0);
      end
      do_op(8'd5, 8'd6, 8'h0B, 1'b0, 0);

      // Random operand pairs with random stalls.
      for (int i = 0; i < 20; i++) begin
         logic [7:0] a;
         logic [7:0] b;
         int         s;
         a = 8'($urandom);
         b = 8'($urandom);
         s = int'($signed(a)) + int'($signed(b));
         do_op(a, b, 8'((int'(a) + int'(b)) % 256), (s > 127) || (s < -128),
               int'($urandom_range(0, 4)));
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_adder_8b.md
SERIAL_ADDER_8B -- requirements
Module: serial_adder_8b

Interface
REQ-001 The block SHALL have parameter NBITS, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_val, input, 1, operand pair valid.
REQ-005 The block SHALL have port in_rdy, output, 1, block ready to accept operands.
REQ-006 The block SHALL have ports in0 and in1, input, NBITS each, the addends (two's complement or unsigned).
REQ-007 The block SHALL have port out_val, output, 1, result valid.
REQ-008 The block SHALL have port out_rdy, input, 1, consumer ready for the result.
REQ-009 The block SHALL have port out, output, NBITS, the sum modulo 2^NBITS.

Function
REQ-010 The block SHALL be a three-state FSM: IDLE, CALC, DONE.
REQ-011 In IDLE: in_rdy=1 and out_val=0; in_val=1 at an edge latches in0/in1, clears carry and bit counter, and enters CALC.
REQ-012 In CALC: in_rdy=0 and out_val=0; each cycle adds one bit pair, LSB first, with the carry register, and shifts the sum bit into the result register.
REQ-013 CALC SHALL last exactly NBITS cycles, then enter DONE. With an acceptance edge at T, out_val SHALL rise at edge T+NBITS.
REQ-014 In DONE: out_val=1, in_rdy=0, and out holds the sum stable; out_rdy=1 at an edge returns to IDLE; out_rdy=0 holds DONE indefinitely.
REQ-015 The block SHALL not bypass IDLE: it accepts no new operands in the cycle the result is consumed, so the minimum initiation interval is NBITS+2 cycles.
REQ-016 Carry-out beyond bit NBITS-1 SHALL be discarded (wrap-around).
REQ-017 out SHALL be driven from the result register in all states; its value is meaningful only while out_val=1.
REQ-018 in_val while in_rdy=0 SHALL be ignored; the operands latched at acceptance SHALL not be disturbed by input changes during CALC or DONE.

Reset
REQ-019 reset_n=0 SHALL force IDLE immediately, without waiting for a clock edge, with in_rdy=1, out_val=0, out=0, carry=0, and counter=0.
REQ-020 A reset asserted during CALC or DONE SHALL abort the operation; no out_val for that operation SHALL appear after deassertion.

Configuration
REQ-021 With SERIAL_ADDER_OVFL_EN defined, the block SHALL add output port ovfl (1 bit), equal to signed overflow (carry into MSB XOR carry out of MSB), valid and stable while out_val=1, and reset to 0.
REQ-022 Without SERIAL_ADDER_OVFL_EN, port ovfl and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-023 A shared package SHALL hold the state enum typedef (IDLE/CALC/DONE) and the default-width constant.
REQ-024 The per-bit add SHALL be a sub-module, full_adder_1b (a, b, cin -> sum, cout), instantiated once.
REQ-025 The FSM, counter, operand shift registers, and result register SHALL reside in serial_adder_8b.

Verification
REQ-026 The bench SHALL check: 0+0 accepted at T -> out_val at T+8 with out=0x00; 42+13 -> 0x37.
REQ-027 The bench SHALL check: 127+1 -> out=0x80, ovfl=1 (macro on); 0xFF+0x01 -> out=0x00, ovfl=0.
REQ-028 The bench SHALL check: -42+(-13) -> out=0xC9 (-55); -128+(-1) -> out=0x7F, ovfl=1.
REQ-029 The bench SHALL check backpressure: hold out_rdy=0 for 5 cycles in DONE -> out_val stays 1, out stays stable, in_rdy stays 0; the next acceptance is no earlier than one cycle after out_rdy=1.
REQ-030 The bench SHALL check reset: reset_n pulsed low at CALC bit 3 -> outputs go to reset values immediately; a fresh 5+6 afterwards -> 0x0B at acceptance+8.
REQ-031 The bench SHALL run 20 seeded random operand pairs with random out_rdy stalls, with every out compared against (in0+in1) mod 256.
